// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants, widths and small timing helpers for the
// scan controller and its counters.
package vga_timing_pkg;

    localparam int CNT_W   = 10;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int COLOR_W = 8;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef logic [COLOR_W-1:0] color_t;

    // Timing flags that travel one pixel behind the coordinate they describe.
    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
    } sync_t;

    function automatic int scan_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = scan_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = scan_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    function automatic logic in_pulse(input logic [CNT_W-1:0] cnt, input int start, input int width);
        return (int'(cnt) >= start) && (int'(cnt) < start + width);
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Modulo-N up-counter with enable; exposes the registered count, its next
// value and a combinational wrap flag for chaining.
module scan_counter
    import vga_timing_pkg::*;
#(
    parameter int N = DEF_H_TOTAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] next_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wrap_o  = en_i && (count_q == CNT_W'(N - 1));
        count_d = count_q;
        if (wrap_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign next_o  = count_d;

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster timing master: drives scan coordinates to the sprite logic and
// returns their colour to the DAC pins with matching sync and blanking.
module vga_scan_ctrl
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic               clk,
    input  logic               rst,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    input  logic [COLOR_W-1:0] r,
    input  logic [COLOR_W-1:0] g,
    input  logic [COLOR_W-1:0] b,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n,
    output logic               vga_sync_n,
    output logic               frame_start
);

    localparam int H_TOTAL  = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W    = $clog2(CLK_DIV);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;
    // Flags describing pixel (0,0), which is what x/y present out of reset.
    localparam sync_t DLY_RST = '{hs: (HS_START != 0), vs: (VS_START != 0), vis: 1'b1};

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pix_en;
    logic [CNT_W-1:0] h_count, h_next, v_count, v_next;
    logic             h_wrap, v_wrap;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    sync_t            dly_q, dly_d;
    color_t           vga_r_q, vga_g_q, vga_b_q;
    logic             vga_hs_q, vga_vs_q, vga_blank_q;
    logic             frame_start_q, frame_start_d;

    always_comb begin
        pix_en    = (div_cnt_q == DIV_W'(CLK_DIV - 1));
        div_cnt_d = pix_en ? '0 : div_cnt_q + 1'b1;
    end

    scan_counter #(.N(H_TOTAL)) u_h_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .en_i    (pix_en),
        .count_o (h_count),
        .next_o  (h_next),
        .wrap_o  (h_wrap)
    );

    scan_counter #(.N(V_TOTAL)) u_v_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .en_i    (h_wrap),
        .count_o (v_count),
        .next_o  (v_next),
        .wrap_o  (v_wrap)
    );

    // Coordinates and their flags come from the counters' next state so they
    // land in the same edge as the counters themselves.
    always_comb begin
        dly_d.vis     = (int'(h_next) < H_ACTIVE) && (int'(v_next) < V_ACTIVE);
        dly_d.hs      = !in_pulse(h_next, HS_START, H_SYNC);
        dly_d.vs      = !in_pulse(v_next, VS_START, V_SYNC);
        x_d           = dly_d.vis ? h_next : '0;
        y_d           = dly_d.vis ? v_next[Y_W-1:0] : '0;
        frame_start_d = pix_en && (h_count == CNT_W'(H_TOTAL - 1))
                        && (v_count == CNT_W'(V_ACTIVE - 1)) && !v_wrap;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q     <= '0;
            x_q           <= '0;
            y_q           <= '0;
            dly_q         <= DLY_RST;
            vga_r_q       <= '0;
            vga_g_q       <= '0;
            vga_b_q       <= '0;
            vga_hs_q      <= 1'b1;
            vga_vs_q      <= 1'b1;
            vga_blank_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            frame_start_q <= frame_start_d;
            if (pix_en) begin
                x_q         <= x_d;
                y_q         <= y_d;
                dly_q       <= dly_d;
                vga_hs_q    <= dly_q.hs;
                vga_vs_q    <= dly_q.vs;
                vga_blank_q <= dly_q.vis;
                vga_r_q     <= dly_q.vis ? r : '0;
                vga_g_q     <= dly_q.vis ? g : '0;
                vga_b_q     <= dly_q.vis ? b : '0;
            end
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign vga_r       = vga_r_q;
    assign vga_g       = vga_g_q;
    assign vga_b       = vga_b_q;
    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;
    assign vga_blank_n = vga_blank_q;
    assign vga_sync_n  = 1'b0;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: a shrunken raster checked every cycle against a
// position-from-time model, plus a default-sized instance for line timing.
module tb_vga_scan_ctrl;

    localparam int CD  = 2;
    localparam int HA  = 10;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 5;
    localparam int VA  = 8;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FT  = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] r = 8'h00, g = 8'h00, b = 8'h00;
    logic [7:0] vgaR, vgaG, vgaB;
    logic vgaHs, vgaVs, vgaBlankN, vgaSyncN, frameStart;

    logic [9:0] defX;
    logic [8:0] defY;
    logic [7:0] defZero = 8'h00;
    logic [7:0] defR, defG, defB;
    logic defHs, defVs, defBlankN, defSyncN, defFs;

    int assertCount = 0;
    int failCount = 0;
    int n = 0;
    bit chkEn = 0;
    bit monEn = 1;
    bit mode = 0;
    bit lastMode = 0;
    int latWait = 0;
    bit latDone = 0;
    int yMax = 0;
    int fsCount = 0;
    int fsTime0 = -1, fsTime1 = -1;
    logic vsPrev = 1'b1;
    int vsFall = -1, vsLen = -1;
    logic defHsPrev = 1'b1;
    int defFall1 = -1, defFall2 = -1, defLowLen = -1;

    always #5 clk = ~clk;

    vga_scan_ctrl #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .r(r), .g(g), .b(b),
        .vga_r(vgaR), .vga_g(vgaG), .vga_b(vgaB), .vga_hs(vgaHs), .vga_vs(vgaVs),
        .vga_blank_n(vgaBlankN), .vga_sync_n(vgaSyncN), .frame_start(frameStart)
    );

    vga_scan_ctrl dutDefault (
        .clk(clk), .rst(rst), .x(defX), .y(defY), .r(defZero), .g(defZero), .b(defZero),
        .vga_r(defR), .vga_g(defG), .vga_b(defB), .vga_hs(defHs), .vga_vs(defVs),
        .vga_blank_n(defBlankN), .vga_sync_n(defSyncN), .frame_start(defFs)
    );

    // Clock edges seen since reset release; the raster position follows from it.
    always @(posedge clk or negedge rst) begin
        if (!rst) n <= 0;
        else      n <= n + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d (n=%0d)", name, actual, expected, n);
        end
    endtask

    task automatic applyStimulus(input logic rstVal);
        #2 rst = rstVal;
    endtask

    function automatic logic [23:0] patColour(input int h, input int v);
        if (h == 5 && v == 7) return 24'h102030;
        return {8'(h + 'h40), 8'(v + 'h80), 8'(h ^ v ^ 'h5A)};
    endfunction

    // Every cycle: compare against the raster model, then act as the sprite
    // and present the colour for whatever coordinate is now on x/y.
    always @(negedge clk) begin : compareProc
        int k, h, v, hp, vp;
        bit vis, pvis, expHs, expVs, expFs;
        logic [23:0] expRgb;
        if (chkEn) begin
            k = n / CD;
            h = (k % FT) % HT;
            v = (k % FT) / HT;
            vis = (h < HA) && (v < VA);
            if (k == 0) begin
                expHs = 1; expVs = 1; pvis = 0; expRgb = 24'h0;
            end else begin
                hp = ((k - 1) % FT) % HT;
                vp = ((k - 1) % FT) / HT;
                pvis = (hp < HA) && (vp < VA);
                expHs = !(hp >= HA + HFP && hp < HA + HFP + HS);
                expVs = !(vp >= VA + VFP && vp < VA + VFP + VS);
                expRgb = !pvis ? 24'h0 : (lastMode ? 24'hFFFFFF : patColour(hp, vp));
            end
            expFs = (n > 0) && (n % CD == 0) && ((k % FT) == VA * HT);
            checkOutput("x", int'(x), vis ? h : 0);
            checkOutput("y", int'(y), vis ? v : 0);
            checkOutput("vga_hs", int'(vgaHs), int'(expHs));
            checkOutput("vga_vs", int'(vgaVs), int'(expVs));
            checkOutput("vga_blank_n", int'(vgaBlankN), int'(pvis));
            checkOutput("vga_rgb", int'({vgaR, vgaG, vgaB}), int'(expRgb));
            checkOutput("frame_start", int'(frameStart), int'(expFs));
            checkOutput("vga_sync_n", int'(vgaSyncN), 0);

            if (int'(y) > yMax) yMax = int'(y);
            if (frameStart) begin
                if (fsCount == 0) fsTime0 = n;
                if (fsCount == 1) fsTime1 = n;
                fsCount++;
            end
            if (vsPrev && !vgaVs && vsFall < 0) vsFall = n;
            if (!vsPrev && vgaVs && vsFall >= 0 && vsLen < 0) vsLen = n - vsFall;
            vsPrev = vgaVs;

            if (!latDone && latWait > 0) begin
                latWait--;
                if (latWait == 0) begin
                    checkOutput("latency_r", int'(vgaR), 'h10);
                    checkOutput("latency_g", int'(vgaG), 'h20);
                    checkOutput("latency_b", int'(vgaB), 'h30);
                    checkOutput("latency_blank_n", int'(vgaBlankN), 1);
                    latDone = 1;
                end
            end else if (!latDone && !lastMode && !mode && x == 10'd5 && y == 9'd7 && n % CD == 0) begin
                latWait = 2;
            end
        end
        if (mode) {r, g, b} = 24'hFFFFFF;
        else      {r, g, b} = patColour(int'(x), int'(y));
        lastMode = mode;
    end

    // Default-sized instance: record the first horizontal sync pulse.
    always @(negedge clk) begin
        if (monEn && rst) begin
            if (defHsPrev && !defHs) begin
                if (defFall1 < 0) defFall1 = n;
                else if (defFall2 < 0) defFall2 = n;
            end
            if (!defHsPrev && defHs && defFall1 >= 0 && defLowLen < 0) defLowLen = n - defFall1;
            defHsPrev = defHs;
        end
    end

    initial begin : mainProc
        int found;
        $display("[TB] vga_scan_ctrl bench starting");
        repeat (3) @(negedge clk);
        chkEn = 1;
        checkOutput("reset_x", int'(x), 0);
        checkOutput("reset_vga_hs", int'(vgaHs), 1);
        checkOutput("reset_vga_blank_n", int'(vgaBlankN), 0);
        applyStimulus(1'b1);

        repeat (3400) @(negedge clk);
        monEn = 0;
        mode = 1;
        repeat (600) @(negedge clk);
        mode = 0;

        found = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (((n / CD) % FT) == 47) begin
                found = 1;
                break;
            end
        end
        checkOutput("midreset_reached", found, 1);
        checkOutput("pre_reset_x", int'(x), 7);
        checkOutput("pre_reset_y", int'(y), 2);
        applyStimulus(1'b0);
        #1;
        checkOutput("midreset_x", int'(x), 0);
        checkOutput("midreset_vga_hs", int'(vgaHs), 1);
        checkOutput("midreset_vga_blank_n", int'(vgaBlankN), 0);
        checkOutput("midreset_rgb", int'({vgaR, vgaG, vgaB}), 0);
        repeat (5) @(negedge clk);
        checkOutput("held_reset_x", int'(x), 0);
        applyStimulus(1'b1);
        @(negedge clk);
        checkOutput("release_x_1clk", int'(x), 0);
        @(negedge clk);
        checkOutput("release_x_2clk", int'(x), 1);
        checkOutput("release_vga_hs", int'(vgaHs), 1);

        repeat (1100) @(negedge clk);

        checkOutput("def_hs_first_fall", defFall1, 1314);
        checkOutput("def_hs_second_fall", defFall2, 2914);
        checkOutput("def_hs_low_len", defLowLen, 192);
        checkOutput("frame_start_first", fsTime0, 320);
        checkOutput("frame_start_second", fsTime1, 840);
        checkOutput("vs_low_len", vsLen, 80);
        checkOutput("latency_seen", int'(latDone), 1);
        checkOutput("y_max", yMax, VA - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
